// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------
// alu_pkg : opcodes, FSM states and latency constants for alu_cplx_seq
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int OP_PASSA = 0;
  localparam int OP_PASSB = 1;
  localparam int OP_ADD   = 2;
  localparam int OP_SUB   = 3;
  localparam int OP_CMUL  = 4;
  localparam int OP_RMUL  = 6;
  localparam int OP_CMP   = 8;

  localparam int LAT_PASS   = 1;
  localparam int LAT_ADDSUB = 2;
  localparam int LAT_RMUL   = 4;
  localparam int LAT_CMUL   = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_MUL    = 2'd2,
    S_CMB    = 2'd3
  } state_t;

  // Capture edge + combine edge frame the product edges, hence LAT - 3.
  function automatic logic [1:0] last_prod(input logic is_cmul);
    return is_cmul ? 2'(LAT_CMUL - 3) : 2'(LAT_RMUL - 3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cplx_seq_if.sv
// ----------------------------------------------------------------------
// alu_cplx_seq_if : start/done request bus of the complex ALU
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface alu_cplx_seq_if #(
  parameter int W   = 32,
  parameter int OPW = 5
);
  logic             start;
  logic [2*W-1:0]   inA;
  logic [2*W-1:0]   inB;
  logic [OPW-1:0]   opr;
  logic [2*W-1:0]   outAB;
  logic             done;
  logic             busy;
  logic             err;
  logic             ovf;

  modport master (output start, inA, inB, opr,
                  input  outAB, done, busy, err, ovf);
  modport slave  (input  start, inA, inB, opr,
                  output outAB, done, busy, err, ovf);
endinterface

`default_nettype wire

// File: rtl/alu_mul_fx.sv
// ----------------------------------------------------------------------
// alu_mul_fx : registered signed WxW multiply, >>>FRAC rescale, optional
//              saturation and overflow flag under ALU_SAT_EN. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module alu_mul_fx #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o,
  output logic         ovf_o
);

  logic signed [2*W-1:0] w_ax;
  logic signed [2*W-1:0] w_bx;
  logic signed [2*W-1:0] w_full;
  logic signed [2*W-1:0] w_shift;
  logic [W-1:0]          p_d;
  logic                  ovf_d;

  assign w_ax    = {{W{a_i[W-1]}}, a_i};
  assign w_bx    = {{W{b_i[W-1]}}, b_i};
  assign w_full  = w_ax * w_bx;
  assign w_shift = w_full >>> FRAC;

`ifdef ALU_SAT_EN
  logic w_ext_ok;
  // The kept W bits are exact only if everything above is a sign extension.
  assign w_ext_ok = (&w_shift[2*W-1:W-1]) | ~(|w_shift[2*W-1:W-1]);

  always_comb begin
    ovf_d = ~w_ext_ok;
    p_d   = w_shift[W-1:0];
    if (!w_ext_ok) begin
      p_d = {w_shift[2*W-1], {(W-1){~w_shift[2*W-1]}}};
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_shift[2*W-1:W];
  assign p_d   = w_shift[W-1:0];
  assign ovf_d = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_o   <= '0;
      ovf_o <= 1'b0;
    end else if (en_i) begin
      p_o   <= p_d;
      ovf_o <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cplx_seq.sv
// ----------------------------------------------------------------------
// alu_cplx_seq : sequential fixed-point complex/real ALU with shared
//                multiplier; ALU_SAT_EN enables saturation + ovf. rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module alu_cplx_seq
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int OPW  = 5
) (
  input  logic          clock,
  input  logic          reset,
  alu_cplx_seq_if.slave bus
);

  state_t           state_q, state_d;
  logic [2*W-1:0]   opa_q, opa_d;
  logic [2*W-1:0]   opb_q, opb_d;
  logic [2*W-1:0]   out_q, out_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [W-1:0]     p0_q, p0_d;
  logic [W-1:0]     p1_q, p1_d;
  logic [W-1:0]     p2_q, p2_d;
  logic             povf_q, povf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0]     mul_a, mul_b, mul_p;
  logic             mul_en, mul_ovf;
  logic [31:0]      w_op_in, w_op_q;
  logic [W:0]       w_re_as, w_im_as, w_re_cm, w_im_cm;

  // Returns {overflow, part}; wraps by default, saturates under ALU_SAT_EN.
  function automatic logic [W:0] part_op(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         sub);
`ifdef ALU_SAT_EN
    logic [W:0] s;
    s = sub ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
    if (s[W] != s[W-1]) return {1'b1, s[W], {(W-1){~s[W]}}};
    return {1'b0, s[W-1:0]};
`else
    return {1'b0, (sub ? x - y : x + y)};
`endif
  endfunction

  assign w_op_in = 32'(bus.opr);
  assign w_op_q  = 32'(op_q);

  assign w_re_as = part_op(opa_q[2*W-1:W], opb_q[2*W-1:W], w_op_q == OP_SUB);
  assign w_im_as = part_op(opa_q[W-1:0],   opb_q[W-1:0],   w_op_q == OP_SUB);
  assign w_re_cm = part_op(p0_q, p1_q, 1'b1);
  assign w_im_cm = part_op(p2_q, mul_p, 1'b0);

  assign mul_en = (state_q == S_MUL);

  // Product order ac, bd, ad, bc; the real multiply uses the first two.
  always_comb begin
    mul_a = opa_q[2*W-1:W];
    mul_b = opb_q[2*W-1:W];
    case (cnt_q)
      2'd1: begin mul_a = opa_q[W-1:0];   mul_b = opb_q[W-1:0];   end
      2'd2: begin mul_a = opa_q[2*W-1:W]; mul_b = opb_q[W-1:0];   end
      2'd3: begin mul_a = opa_q[W-1:0];   mul_b = opb_q[2*W-1:W]; end
      default: ;
    endcase
  end

  alu_mul_fx #(.W(W), .FRAC(FRAC)) u_mul (
    .clock (clock),
    .reset (reset),
    .en_i  (mul_en),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (mul_p),
    .ovf_o (mul_ovf)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    povf_d  = povf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovf_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opa_d = bus.inA;
          opb_d = bus.inB;
          op_d  = bus.opr;
          case (w_op_in)
            OP_PASSA: begin out_d = bus.inA; done_d = 1'b1; end
            OP_PASSB: begin out_d = bus.inB; done_d = 1'b1; end
            OP_CMP: begin
              out_d  = {{(2*W-1){1'b0}}, (bus.inA == bus.inB)};
              done_d = 1'b1;
            end
            OP_ADD, OP_SUB: state_d = S_ADDSUB;
            OP_CMUL, OP_RMUL: begin
              state_d = S_MUL;
              cnt_d   = 2'd0;
              povf_d  = 1'b0;
            end
            default: begin done_d = 1'b1; err_d = 1'b1; end
          endcase
        end
      end
      S_ADDSUB: begin
        out_d   = {w_re_as[W-1:0], w_im_as[W-1:0]};
        ovf_d   = w_re_as[W] | w_im_as[W];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_MUL: begin
        // Each edge banks the product finished on the previous edge.
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd1:    p0_d = mul_p;
          2'd2:    p1_d = mul_p;
          2'd3:    p2_d = mul_p;
          default: ;
        endcase
        if (cnt_q != 2'd0) povf_d = povf_q | mul_ovf;
        if (cnt_q == last_prod(w_op_q == OP_CMUL)) begin
          state_d = S_CMB;
          cnt_d   = 2'd0;
        end
      end
      S_CMB: begin
        if (w_op_q == OP_CMUL) begin
          out_d = {w_re_cm[W-1:0], w_im_cm[W-1:0]};
          ovf_d = povf_q | mul_ovf | w_re_cm[W] | w_im_cm[W];
        end else begin
          out_d = {p0_q, mul_p};
          ovf_d = povf_q | mul_ovf;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      cnt_q   <= 2'd0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      povf_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      povf_q  <= povf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.outAB = out_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_cplx_seq.sv
// ----------------------------------------------------------------------
// tb_alu_cplx_seq : directed self-checking bench for alu_cplx_seq
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_alu_cplx_seq;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_cplx_seq_if #(.W(32), .OPW(5)) bus ();

  alu_cplx_seq #(.W(32), .FRAC(16), .OPW(5)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.opr   = op;
    bus.inA   = a;
    bus.inB   = b;
    tick();
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.opr   = '0;
    bus.inA   = '0;
    bus.inB   = '0;
    tick();
    tick();
    chk("rst_out",  bus.outAB, 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_err",  64'(bus.err),  64'h0);
    chk("rst_ovf",  64'(bus.ovf),  64'h0);
    rst_n = 1'b1;
    tick();

    // complex multiply (1+2j)*(3+4j) = -5+10j
    run_op(5'd4, 64'h00010000_00020000, 64'h00030000_00040000, lat, bcnt);
    chk("cmul_out",  bus.outAB, 64'hFFFB0000_000A0000);
    chk("cmul_lat",  64'(lat),  64'd6);
    chk("cmul_busy", 64'(bcnt), 64'd5);
    chk("cmul_err",  64'(bus.err), 64'h0);
    chk("cmul_ovf",  64'(bus.ovf), 64'h0);
    tick();
    chk("cmul_done_pulse", 64'(bus.done), 64'h0);

    // real multiply {1.5,-2}*{2,0.5} = {3,-1}
    run_op(5'd6, 64'h00018000_FFFE0000, 64'h00020000_00008000, lat, bcnt);
    chk("rmul_out", bus.outAB, 64'h00030000_FFFF0000);
    chk("rmul_lat", 64'(lat),  64'd4);

    // add with overflow in RE
    run_op(5'd2, 64'h7FFFFFFF_00010000, 64'h00000001_00020000, lat, bcnt);
`ifdef ALU_SAT_EN
    chk("add_out", bus.outAB, 64'h7FFFFFFF_00030000);
    chk("add_ovf", 64'(bus.ovf), 64'h1);
`else
    chk("add_out", bus.outAB, 64'h80000000_00030000);
    chk("add_ovf", 64'(bus.ovf), 64'h0);
`endif
    chk("add_lat", 64'(lat), 64'd2);

    run_op(5'd3, 64'h00050000_00000000, 64'h00020000_00010000, lat, bcnt);
    chk("sub_out", bus.outAB, 64'h00030000_FFFF0000);
    chk("sub_lat", 64'(lat), 64'd2);

    run_op(5'd1, 64'h11112222_33334444, 64'h55556666_77778888, lat, bcnt);
    chk("passb_out", bus.outAB, 64'h55556666_77778888);
    chk("passb_lat", 64'(lat), 64'd1);

    // compare, back-to-back with start held
    bus.start = 1'b1;
    bus.opr   = 5'd8;
    bus.inA   = 64'hDEADBEEF_01234567;
    bus.inB   = 64'hDEADBEEF_01234567;
    tick();
    chk("cmp_eq_done", 64'(bus.done), 64'h1);
    chk("cmp_eq_out",  bus.outAB, 64'h1);
    chk("cmp_eq_busy", 64'(bus.busy), 64'h0);
    bus.inB = 64'hDEADBEEF_01234568;
    tick();
    chk("cmp_ne_done", 64'(bus.done), 64'h1);
    chk("cmp_ne_out",  bus.outAB, 64'h0);
    chk("cmp_ne_busy", 64'(bus.busy), 64'h0);
    bus.start = 1'b0;
    tick();
    chk("cmp_done_drop", 64'(bus.done), 64'h0);

    // reserved opcode leaves outAB alone
    run_op(5'd0, 64'hCAFEF00D_12345678, 64'h0, lat, bcnt);
    chk("passa_out", bus.outAB, 64'hCAFEF00D_12345678);
    chk("passa_lat", 64'(lat), 64'd1);
    run_op(5'd5, 64'h1, 64'h2, lat, bcnt);
    chk("rsv_lat", 64'(lat), 64'd1);
    chk("rsv_err", 64'(bus.err), 64'h1);
    chk("rsv_out", bus.outAB, 64'hCAFEF00D_12345678);
    tick();
    chk("rsv_err_drop", 64'(bus.err), 64'h0);
    run_op(5'd17, 64'h1, 64'h2, lat, bcnt);
    chk("rsv17_err", 64'(bus.err), 64'h1);

    // start and operand changes while busy are ignored
    bus.start = 1'b1;
    bus.opr   = 5'd4;
    bus.inA   = 64'h00010000_00020000;
    bus.inB   = 64'h00030000_00040000;
    tick();
    bus.opr = 5'd0;
    bus.inA = 64'h0BADBEEF_0BADBEEF;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_out",   bus.outAB, 64'hFFFB0000_000A0000);

    // async reset in the middle of a complex multiply
    bus.start = 1'b1;
    bus.opr   = 5'd4;
    bus.inA   = 64'h00010000_00010000;
    bus.inB   = 64'h00010000_00010000;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",  bus.outAB, 64'h0);
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
    chk("mid_rst_done", 64'(bus.done), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    chk("abort_ndone", 64'(ndone), 64'd0);
    run_op(5'd2, 64'h00010000_00000003, 64'h00020000_FFFFFFFF, lat, bcnt);
    chk("post_rst_out", bus.outAB, 64'h00030000_00000002);
    chk("post_rst_lat", 64'(lat), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_cplx_seq.md
Name: alu_cplx_seq

Overview:
- Parametrised successor to the current complex/real ALU: fixed-point complex operands {RE,IM}, start/done handshake, registered result.
- Adds operand capture, a shared sequential multiplier (real and complex multiply), sub, busy and error reporting.
- Sits between the register file/datapath controller and the polar/divider units. Division and polar opcodes stay reserved here.

Parameters:
- W, 32, width of each real/imag part; buses are 2W with RE in [2W-1:W], IM in [W-1:0]
- FRAC, 16, fractional bits of the signed Q(W-FRAC).FRAC format
- OPW, 5, opcode width

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only while idle
- inA  in  2W  operand A {RE,IM}
- inB  in  2W  operand B {RE,IM}
- opr  in  OPW  opcode
- outAB  out  2W  result, registered, held until next done
- done  out  1  one-cycle pulse, outAB valid
- busy  out  1  high while an operation is in flight
- err  out  1  pulses with done on a reserved opcode
- ovf  out  1  pulses with done if any part saturated (0 without macro)

Behaviour:
- Reset (reset=0, async): outAB=0, done=0, busy=0, err=0, ovf=0, state=IDLE. Aborts any operation mid-flight; no done is produced for it.
- Opcodes:
  - 0: A
  - 1: B
  - 2: A+B per part
  - 3: A-B per part
  - 4: complex A*B
  - 6: RE(A)*RE(B), IM(A)*IM(B)
  - 8: outAB={2W-1 zeros, A==B}
  - 5, 7, 9, 10 and 11..2^OPW-1: reserved
- Latency L counts rising edges, starting with the edge that samples start and ending with the edge that sets done:
  - 0, 1, 8 and reserved: L=1
  - 2, 3: L=2
  - 6: L=4
  - 4: L=6
- FSM states IDLE, ADDSUB, MUL, CMB.
- IDLE + start:
  - inA, inB, opr latched.
  - L=1 ops write outAB and pulse done on the same edge; they stay in IDLE.
  - Reserved opcodes pulse done and err; outAB is unchanged.
- ADDSUB: one edge; writes result and done, returns to IDLE.
- MUL: shared registered W x W signed multiplier, one product per edge, tracked by a 2-bit product counter.
  - Product order for opcode 4: ac, bd, ad, bc (A=a+jb, B=c+jd).
  - Product order for opcode 6: RE*RE, IM*IM.
- CMB: one edge.
  - Opcode 4: RE=ac-bd, IM=ad+bc.
  - Opcode 6: places the two products.
  - Writes outAB, pulses done, returns to IDLE.
- Product rescale: full 2W-bit product >>> FRAC, lower W bits kept (truncation toward -inf).
- Add/sub/combine: modulo 2^W per part (wrap).
- busy = (state != IDLE). start while busy is ignored, and operand changes while busy have no effect.
- The done edge returns the FSM to IDLE, so start held during the done-high cycle is accepted at the next edge. L=1 ops accept back-to-back every cycle.
- done, err and ovf are single-cycle pulses and deassert on the next edge unless re-asserted.

Optional Feature:
- Macro: ALU_SAT_EN
- Defined:
  - Every part result (add, sub, rescaled product, combine) saturates to 2^(W-1)-1 / -2^(W-1) on overflow.
  - Product overflow means the discarded upper bits are not a sign extension.
  - ovf pulses with done if any part saturated.
- Undefined: wrap/truncate as above; ovf tied 0.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_CMUL, OP_RMUL, OP_CMP)
  - FSM state encodings
  - the latency constants per opcode
- One sub-module, alu_mul_fx: registered signed W x W multiply with >>>FRAC rescale and, under ALU_SAT_EN, saturate plus an overflow flag.

Test Plan (W=32, FRAC=16, 1.0 = 0x00010000):
- Complex mul: inA={0x00010000,0x00020000}, inB={0x00030000,0x00040000}, opr=4. Expect outAB={0xFFFB0000,0x000A0000} (-5+10j) with done at L=6, busy high for 5 cycles.
- Real mul: inA={0x00018000,0xFFFE0000}, inB={0x00020000,0x00008000}, opr=6. Expect outAB={0x00030000,0xFFFF0000} at L=4.
- Add overflow: RE(A)=0x7FFFFFFF, RE(B)=0x00000001, opr=2.
  - Without macro: RE out=0x80000000, ovf=0.
  - With ALU_SAT_EN: RE out=0x7FFFFFFF, ovf=1.
- Compare and back-to-back: opr=8 with A==B for one cycle, then A!=B the next. Expect done both cycles, outAB=1 then 0, busy stays 0.
- Reserved and ignored start:
  - opr=5 → done=err=1 at L=1, outAB unchanged.
  - start pulsed during an active opr=4 → ignored, exactly one done.
- Reset mid-op: reset=0 asynchronously at cycle 3 of opr=4. All outputs 0 immediately, no done. The next start with opr=2 completes normally at L=2.
